// File: rtl/a_axi_write_slr_receiver_pkg.sv
`default_nettype none
// ============================================================================
// Module      : a_axi_write_slr_receiver_pkg
// Description : Shared constants for the SLR-side AXI-Lite control write
//               receiver: default bus widths, register count, the word
//               address offset and the position of the ap_start control bit
//               in register 0. Also provides a byte-merge helper.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package a_axi_write_slr_receiver_pkg;

    localparam int c_ADDR_WIDTH     = 9;
    localparam int c_DATA_WIDTH     = 32;
    localparam int c_WSTRB_WIDTH    = c_DATA_WIDTH / 8;
    localparam int c_NUM_REGS       = 16;
    localparam int c_WR_COUNT_WIDTH = 16;

    // Byte address bits below this position select a byte inside a word.
    localparam int c_WORD_LSB       = 2;

    // Control bit in register 0 that launches the kernel; it never stores.
    localparam int c_AP_START_BIT   = 0;

    // Byte-lane write merge: take the new byte when its strobe is set.
    function automatic logic [7:0] merge_byte(
        input logic [7:0] old_byte,
        input logic [7:0] new_byte,
        input logic       enable
    );
        return enable ? new_byte : old_byte;
    endfunction

endpackage
`default_nettype wire

// File: rtl/a_axi_write_slr_receiver_if.sv
`default_nettype none
// ============================================================================
// Module      : a_axi_write_slr_receiver_if
// Description : AXI-Lite write address / write data channels as delivered by
//               the per-SLR relay station (no B channel at this point).
// Signals     : awvalid/awready/awaddr  - write address channel
//               wvalid/wready/wdata/wstrb - write data channel
// Modports    : master - relay-station side (drives VALID and payload)
//               slave  - receiver side (drives READY)
// Revision    : 1.0 - initial release
// ============================================================================
interface a_axi_write_slr_receiver_if
    import a_axi_write_slr_receiver_pkg::*;
#(
    parameter int ADDR_WIDTH  = c_ADDR_WIDTH,
    parameter int DATA_WIDTH  = c_DATA_WIDTH,
    parameter int WSTRB_WIDTH = c_WSTRB_WIDTH
) ();

    logic                   awvalid;
    logic                   awready;
    logic [ADDR_WIDTH-1:0]  awaddr;
    logic                   wvalid;
    logic                   wready;
    logic [DATA_WIDTH-1:0]  wdata;
    logic [WSTRB_WIDTH-1:0] wstrb;

    modport master (
        output awvalid, awaddr, wvalid, wdata, wstrb,
        input  awready, wready
    );

    modport slave (
        input  awvalid, awaddr, wvalid, wdata, wstrb,
        output awready, wready
    );

endinterface
`default_nettype wire

// File: rtl/a_axi_write_slr_receiver_hold_slot.sv
`default_nettype none
// ============================================================================
// Module      : a_axi_hold_slot
// Description : One-entry valid/ready holding register. Accepts a beat when
//               empty, or when the held beat is being popped in the same
//               cycle (so a full slot still sustains one beat per cycle).
//               READY depends only on state, reset and pop - never on VALID.
// Ports       : clk, rst              - clock, synchronous active-high reset
//               in_valid/in_ready     - upstream handshake
//               in_data               - upstream payload
//               full/data             - held beat status and payload
//               pop                   - consumer takes the held beat
// Revision    : 1.0 - initial release
// ============================================================================
module a_axi_hold_slot #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             full,
    output logic [WIDTH-1:0] data,
    input  logic             pop
);

    logic             r_full;
    logic [WIDTH-1:0] r_data;

    assign in_ready = !rst && (!r_full || pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_full <= 1'b0;
            r_data <= '0;
        end else if (in_valid && in_ready) begin
            // Covers the pop-and-refill case: the slot stays full.
            r_full <= 1'b1;
            r_data <= in_data;
        end else if (pop) begin
            r_full <= 1'b0;
        end
    end

    assign full = r_full;
    assign data = r_data;

endmodule
`default_nettype wire

// File: rtl/a_axi_write_slr_receiver.sv
`default_nettype none
// ============================================================================
// Module      : a_axi_write_slr_receiver
// Description : SLR-local receiver for AXI-Lite control writes. AW and W are
//               buffered independently in one-entry slots, paired in arrival
//               order, and committed into a local byte-maskable register
//               bank. Register 0 bit 0 is a self-clearing ap_start bit.
// Ports       : ap_clk, ap_rst      - clock, synchronous active-high reset
//               s_axi_control       - AW/W channels (slave modport)
//               regs_out            - register bank, reg i at [i*DW +: DW]
//               ap_start_pulse      - one-cycle pulse on write of 1 to bit 0
//               wr_valid            - one-cycle pulse per committed write
//               wr_index            - index of last in-range committed write
//               wr_count            - committed writes (wraps at 16 bits)
// Revision    : 1.0 - initial release
// ============================================================================
module a_axi_write_slr_receiver
    import a_axi_write_slr_receiver_pkg::*;
#(
    parameter int C_S_AXI_CONTROL_ADDR_WIDTH  = c_ADDR_WIDTH,
    parameter int C_S_AXI_CONTROL_DATA_WIDTH  = c_DATA_WIDTH,
    parameter int C_S_AXI_CONTROL_WSTRB_WIDTH = c_WSTRB_WIDTH,
    parameter int NUM_REGS                    = c_NUM_REGS
) (
    input  logic                                         ap_clk,
    input  logic                                         ap_rst,
    a_axi_write_slr_receiver_if.slave                    s_axi_control,
    output logic [NUM_REGS*C_S_AXI_CONTROL_DATA_WIDTH-1:0] regs_out,
    output logic                                         ap_start_pulse,
    output logic                                         wr_valid,
    output logic [$clog2(NUM_REGS)-1:0]                  wr_index,
    output logic [c_WR_COUNT_WIDTH-1:0]                  wr_count
);

    localparam int c_DW       = C_S_AXI_CONTROL_DATA_WIDTH;
    localparam int c_SW       = C_S_AXI_CONTROL_WSTRB_WIDTH;
    localparam int c_IDX_W    = C_S_AXI_CONTROL_ADDR_WIDTH - c_WORD_LSB;
    localparam int c_WR_IDX_W = $clog2(NUM_REGS);

    logic               w_aw_full;
    logic [c_IDX_W-1:0] w_aw_index;
    logic               w_w_full;
    logic [c_SW+c_DW-1:0] w_w_payload;
    logic [c_DW-1:0]    w_w_data;
    logic [c_SW-1:0]    w_w_strb;
    logic               w_commit;
    logic               w_in_range;
    logic               w_start;
    logic               w_unused_addr_lsb;

    // Only the word index is worth holding; byte offset bits are ignored.
    assign w_unused_addr_lsb = &{1'b0, s_axi_control.awaddr[c_WORD_LSB-1:0]};

    a_axi_hold_slot #(
        .WIDTH (c_IDX_W)
    ) u_aw_slot (
        .clk      (ap_clk),
        .rst      (ap_rst),
        .in_valid (s_axi_control.awvalid),
        .in_ready (s_axi_control.awready),
        .in_data  (s_axi_control.awaddr[C_S_AXI_CONTROL_ADDR_WIDTH-1:c_WORD_LSB]),
        .full     (w_aw_full),
        .data     (w_aw_index),
        .pop      (w_commit)
    );

    a_axi_hold_slot #(
        .WIDTH (c_SW + c_DW)
    ) u_w_slot (
        .clk      (ap_clk),
        .rst      (ap_rst),
        .in_valid (s_axi_control.wvalid),
        .in_ready (s_axi_control.wready),
        .in_data  ({s_axi_control.wstrb, s_axi_control.wdata}),
        .full     (w_w_full),
        .data     (w_w_payload),
        .pop      (w_commit)
    );

    assign w_w_data = w_w_payload[c_DW-1:0];
    assign w_w_strb = w_w_payload[c_SW+c_DW-1:c_DW];

    // With one entry per channel, the held AW and W are always the oldest
    // of each, so pairing whenever both are present keeps arrival order.
    assign w_commit   = w_aw_full && w_w_full;
    assign w_in_range = (32'(w_aw_index) < 32'(NUM_REGS));
    assign w_start    = w_commit && w_in_range && (w_aw_index == '0)
                      && w_w_strb[c_AP_START_BIT / 8]
                      && w_w_data[c_AP_START_BIT];

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_regs
        logic [c_DW-1:0] r_reg;
        logic            w_sel;

        assign w_sel = w_commit && w_in_range && (32'(w_aw_index) == 32'(i));

        always_ff @(posedge ap_clk) begin
            if (ap_rst) begin
                r_reg <= '0;
            end else if (w_sel) begin
                for (int b = 0; b < c_SW; b++) begin
                    r_reg[8*b +: 8] <= merge_byte(r_reg[8*b +: 8],
                                                  w_w_data[8*b +: 8],
                                                  w_w_strb[b]);
                end
                // The start bit only generates a pulse; it never stores.
                if (i == 0) begin
                    r_reg[c_AP_START_BIT] <= 1'b0;
                end
            end
        end

        assign regs_out[i*c_DW +: c_DW] = r_reg;
    end

    logic                        r_wr_valid;
    logic                        r_ap_start_pulse;
    logic [c_WR_IDX_W-1:0]       r_wr_index;
    logic [c_WR_COUNT_WIDTH-1:0] r_wr_count;

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_wr_valid       <= 1'b0;
            r_ap_start_pulse <= 1'b0;
            r_wr_index       <= '0;
            r_wr_count       <= '0;
        end else begin
            r_wr_valid       <= w_commit;
            r_ap_start_pulse <= w_start;
            if (w_commit) begin
                r_wr_count <= r_wr_count + 1'b1;
            end
            // Out-of-range writes are counted but leave the index alone.
            if (w_commit && w_in_range) begin
                r_wr_index <= w_aw_index[c_WR_IDX_W-1:0];
            end
        end
    end

    assign wr_valid       = r_wr_valid;
    assign ap_start_pulse = r_ap_start_pulse;
    assign wr_index       = r_wr_index;
    assign wr_count       = r_wr_count;

endmodule
`default_nettype wire
